// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access, with data given priority.
// Grant counters are built only when MEM_ARB_STATS_EN is defined; otherwise they read as constant zero.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ready,
  output logic [15:0] i_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic [15:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic [15:0] i_grant_cnt,
  output logic [15:0] d_grant_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } state_t;

  state_t      state_q, state_d;
  logic        memWe_q, memWe_d;
  logic [15:0] memAddr_q, memAddr_d;
  logic [15:0] memWdata_q, memWdata_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      memWe_q    <= 1'b0;
      memAddr_q  <= 16'h0000;
      memWdata_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
    end
  end

  // Requests are only sampled in IDLE, so a request still held after its ready cannot be issued twice.
  always_comb begin
    state_d    = state_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d    = D_BUSY;
          memWe_d    = d_we;
          memAddr_d  = d_addr;
          memWdata_d = d_wdata;
        end else if (i_req) begin
          state_d   = I_BUSY;
          memWe_d   = 1'b0;
          memAddr_d = i_addr;
        end
      end
      I_BUSY: if (mem_ready) state_d = IDLE;
      D_BUSY: if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req   = (state_q == I_BUSY) || (state_q == D_BUSY);
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;

  assign i_ready   = (state_q == I_BUSY) && mem_ready;
  assign d_ready   = (state_q == D_BUSY) && mem_ready;
  assign i_data    = mem_rdata;
  assign d_rdata   = mem_rdata;

  assign stall_if  = i_req && !i_ready;
  assign stall_mem = d_req && !d_ready;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] iGrantCnt_q;
  logic [15:0] dGrantCnt_q;

  // Saturating completion counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iGrantCnt_q <= 16'h0000;
      dGrantCnt_q <= 16'h0000;
    end else begin
      if (i_ready && (iGrantCnt_q != 16'hFFFF)) iGrantCnt_q <= iGrantCnt_q + 16'd1;
      if (d_ready && (dGrantCnt_q != 16'hFFFF)) dGrantCnt_q <= dGrantCnt_q + 16'd1;
    end
  end

  assign i_grant_cnt = iGrantCnt_q;
  assign d_grant_cnt = dGrantCnt_q;
`else
  assign i_grant_cnt = 16'h0000;
  assign d_grant_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected completions, a monitor checks each ready pulse.
// Grant counter expectations depend on MEM_ARB_STATS_EN.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ready;
  logic [15:0] i_data;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ready;
  logic [15:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic [15:0] i_grant_cnt;
  logic [15:0] d_grant_cnt;

  logic        autoReady;
  logic        strayReady;
  int          memLat;
  int          waitCnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        isData;
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic        chkWdata;
    logic [15:0] rdata;
    logic        chkData;
  } exp_t;

  exp_t expQ[$];

  mem_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ready     (i_ready),
    .i_data      (i_data),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ready     (d_ready),
    .d_rdata     (d_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .stall_if    (stall_if),
    .stall_mem   (stall_mem),
    .i_grant_cnt (i_grant_cnt),
    .d_grant_cnt (d_grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns the address XOR 16'h5A5A, memLat cycles after mem_req rises.
  assign mem_ready = autoReady | strayReady;
  assign mem_rdata = mem_ready ? (mem_addr ^ 16'h5A5A) : 16'h0BAD;

  initial begin
    autoReady = 1'b0;
    waitCnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (autoReady) begin
        autoReady = 1'b0;
        waitCnt   = 0;
      end else if (mem_req && reset_n) begin
        if (waitCnt == memLat) autoReady = 1'b1;
        else waitCnt++;
      end else begin
        waitCnt = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic exp_t mkExp(input logic isData, input logic [15:0] addr, input logic we,
                                 input logic [15:0] wdata, input logic chkWdata,
                                 input logic [15:0] rdata, input logic chkData);
    exp_t e;
    e.isData   = isData;
    e.addr     = addr;
    e.we       = we;
    e.wdata    = wdata;
    e.chkWdata = chkWdata;
    e.rdata    = rdata;
    e.chkData  = chkData;
    return e;
  endfunction

  // Every ready pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (i_ready || d_ready)) begin
        checkOutput("ready_exclusive", 32'(i_ready & d_ready), 32'd0);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ready: got i_ready=%b d_ready=%b expected no pulse", i_ready, d_ready);
        end else begin
          e = expQ.pop_front();
          checkOutput("ready_kind", 32'(d_ready), 32'(e.isData));
          checkOutput("mem_addr_at_ready", 32'(mem_addr), 32'(e.addr));
          checkOutput("mem_we_at_ready", 32'(mem_we), 32'(e.we));
          if (e.chkWdata) checkOutput("mem_wdata_at_ready", 32'(mem_wdata), 32'(e.wdata));
          if (e.chkData) checkOutput("read_data", 32'(e.isData ? d_rdata : i_data), 32'(e.rdata));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 300000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Issues one request, holds it until its ready (bounded), then drops it the following cycle.
  task automatic applyStimulus(input bit isData, input bit we, input logic [15:0] addr,
                               input logic [15:0] wdata, input int lat,
                               input logic [15:0] expRdata, input bit chkData);
    bit seen;
    seen   = 1'b0;
    memLat = lat;
    expQ.push_back(mkExp(isData, addr, we, wdata, isData, expRdata, chkData));
    if (isData) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (isData ? d_ready : i_ready) begin
        checkOutput("stall_drops_on_ready", 32'(isData ? stall_mem : stall_if), 32'd0);
        seen = 1'b1;
        break;
      end
      checkOutput("stall_while_waiting", 32'(isData ? stall_mem : stall_if), 32'd1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got no ready expected ready within 40 cycles (addr %h)", addr);
    end
    nextCycle();
    if (isData) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; strayReady = 1'b1; memLat = 1;

    // Reset values, with a stray memory pulse that must not produce a ready.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("rst_i_ready", 32'(i_ready), 32'd0);
    checkOutput("rst_d_ready", 32'(d_ready), 32'd0);
    checkOutput("rst_i_cnt", 32'(i_grant_cnt), 32'd0);
    checkOutput("rst_d_cnt", 32'(d_grant_cnt), 32'd0);
    nextCycle();
    reset_n = 1'b1;
    strayReady = 1'b0;
    nextCycle();

    // Instruction fetch at 0010, memory answers two cycles after mem_req rises.
    i_req = 1'b1; i_addr = 16'h0010; memLat = 2;
    expQ.push_back(mkExp(1'b0, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h5A4A, 1'b1));
    @(negedge clk);
    checkOutput("t1_stall_if_n", 32'(stall_if), 32'd1);
    checkOutput("t1_mem_req_n", 32'(mem_req), 32'd0);
    @(negedge clk);
    checkOutput("t1_mem_req_n1", 32'(mem_req), 32'd1);
    checkOutput("t1_mem_addr_n1", 32'(mem_addr), 32'h0010);
    checkOutput("t1_mem_we_n1", 32'(mem_we), 32'd0);
    checkOutput("t1_stall_if_n1", 32'(stall_if), 32'd1);
    @(negedge clk);
    checkOutput("t1_i_ready_n2", 32'(i_ready), 32'd0);
    checkOutput("t1_stall_if_n2", 32'(stall_if), 32'd1);
    @(negedge clk);
    checkOutput("t1_i_ready_n3", 32'(i_ready), 32'd1);
    checkOutput("t1_stall_if_n3", 32'(stall_if), 32'd0);
    nextCycle();
    i_req = 1'b0;
    @(negedge clk);
    checkOutput("t1_idle_after", 32'(mem_req), 32'd0);
    nextCycle();

    // Data write, fields checked at the ready pulse by the monitor.
    applyStimulus(1'b1, 1'b1, 16'h0080, 16'hBEEF, 1, 16'h0000, 1'b0);
    nextCycle();

    // Both requests together: data first, one idle cycle, then instruction.
    memLat = 1;
    expQ.push_back(mkExp(1'b1, 16'h0040, 1'b0, 16'h1234, 1'b1, 16'h5A1A, 1'b1));
    expQ.push_back(mkExp(1'b0, 16'h0020, 1'b0, 16'h1234, 1'b1, 16'h5A7A, 1'b1));
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040; d_wdata = 16'h1234;
    i_req = 1'b1; i_addr = 16'h0020;
    @(negedge clk);
    checkOutput("t3_stall_mem_n", 32'(stall_mem), 32'd1);
    checkOutput("t3_stall_if_n", 32'(stall_if), 32'd1);
    @(negedge clk);
    checkOutput("t3_d_first_addr", 32'(mem_addr), 32'h0040);
    checkOutput("t3_stall_if_n1", 32'(stall_if), 32'd1);
    @(negedge clk);
    checkOutput("t3_d_ready", 32'(d_ready), 32'd1);
    checkOutput("t3_stall_mem_drop", 32'(stall_mem), 32'd0);
    checkOutput("t3_stall_if_n2", 32'(stall_if), 32'd1);
    nextCycle();
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("t3_idle_gap", 32'(mem_req), 32'd0);
    checkOutput("t3_stall_if_gap", 32'(stall_if), 32'd1);
    @(negedge clk);
    checkOutput("t3_i_addr", 32'(mem_addr), 32'h0020);
    checkOutput("t3_wdata_held", 32'(mem_wdata), 32'h1234);
    checkOutput("t3_stall_if_n4", 32'(stall_if), 32'd1);
    @(negedge clk);
    checkOutput("t3_i_ready", 32'(i_ready), 32'd1);
    checkOutput("t3_stall_if_drop", 32'(stall_if), 32'd0);
    nextCycle();
    i_req = 1'b0;
    nextCycle();

    // Inputs change mid-transaction; the latched fields must hold.
    memLat = 3;
    expQ.push_back(mkExp(1'b1, 16'h0030, 1'b0, 16'h2222, 1'b1, 16'h5A6A, 1'b1));
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030; d_wdata = 16'h2222;
    nextCycle();
    d_addr = 16'h00FF; d_we = 1'b1; d_wdata = 16'hFFFF;
    @(negedge clk);
    checkOutput("t4_addr_held", 32'(mem_addr), 32'h0030);
    checkOutput("t4_we_held", 32'(mem_we), 32'd0);
    checkOutput("t4_wdata_held", 32'(mem_wdata), 32'h2222);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (d_ready) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      checkOutput("t4_ready_seen", 32'(seen), 32'd1);
    end
    nextCycle();
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("t4_idle", 32'(mem_req), 32'd0);
    nextCycle();
    strayReady = 1'b1;
    @(negedge clk);
    checkOutput("t4_stray_i_ready", 32'(i_ready), 32'd0);
    checkOutput("t4_stray_d_ready", 32'(d_ready), 32'd0);
    nextCycle();
    strayReady = 1'b0;
    @(negedge clk);
    checkOutput("t4_still_idle", 32'(mem_req), 32'd0);

`ifdef MEM_ARB_STATS_EN
    checkOutput("cnt_i_mid", 32'(i_grant_cnt), 32'd2);
    checkOutput("cnt_d_mid", 32'(d_grant_cnt), 32'd3);
`else
    checkOutput("cnt_i_off", 32'(i_grant_cnt), 32'd0);
    checkOutput("cnt_d_off", 32'(d_grant_cnt), 32'd0);
`endif

    // Reset during a data transaction, then a late memory pulse.
    nextCycle();
    memLat = 5;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0050; d_wdata = 16'h7777;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_busy", 32'(mem_req), 32'd1);
    #2;
    reset_n = 1'b0;
    d_req = 1'b0;
    #1;
    checkOutput("t5_rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("t5_rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("t5_rst_i_cnt", 32'(i_grant_cnt), 32'd0);
    checkOutput("t5_rst_d_cnt", 32'(d_grant_cnt), 32'd0);
    nextCycle();
    nextCycle();
    reset_n = 1'b1;
    nextCycle();
    strayReady = 1'b1;
    @(negedge clk);
    checkOutput("t5_late_d_ready", 32'(d_ready), 32'd0);
    checkOutput("t5_late_mem_req", 32'(mem_req), 32'd0);
    nextCycle();
    strayReady = 1'b0;
    nextCycle();

    // Zero-latency memory with a new fetch presented right at R+1.
    applyStimulus(1'b0, 1'b0, 16'h0100, 16'h0000, 0, 16'h5B5A, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0102, 16'h0000, 0, 16'h5B58, 1'b1);
    nextCycle();

`ifdef MEM_ARB_STATS_EN
    @(negedge clk);
    checkOutput("cnt_i_after_rst", 32'(i_grant_cnt), 32'd2);
    checkOutput("cnt_d_after_rst", 32'(d_grant_cnt), 32'd0);
    force dut.iGrantCnt_q = 16'hFFFE;
    #1;
    release dut.iGrantCnt_q;
    nextCycle();
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 16'(16'h0200 + k), 16'h0000, 1,
                                              16'(16'h0200 + k) ^ 16'h5A5A, 1'b1);
    @(negedge clk);
    checkOutput("cnt_i_saturate", 32'(i_grant_cnt), 32'hFFFF);
`else
    @(negedge clk);
    checkOutput("cnt_i_off_end", 32'(i_grant_cnt), 32'd0);
    checkOutput("cnt_d_off_end", 32'(d_grant_cnt), 32'd0);
`endif

    nextCycle();
    @(negedge clk);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
